// File: rtl/ram_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_param_pkg
// Description : Shared types and default sizing for the ram_param block.
// Revision    : 1.0  initial release
// ============================================================================
package ram_param_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DEPTH  = 8;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_param_parity.sv
`default_nettype none
// ============================================================================
// Module      : ram_param_parity
// Description : Per-byte even parity generator (one bit per 8-bit lane).
//               Used only when RAM_PARAM_PARITY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module ram_param_parity #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]   data_i,
   output logic [DATA_W/8-1:0] par_o
);

   // XOR-reduce each byte lane independently
   always_comb begin
      par_o = '0;
      for (int i = 0; i < DATA_W/8; i++) begin
         par_o[i] = ^data_i[8*i +: 8];
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
// Module      : ram_param
// Description : Parameterised single-port RAM with byte-lane write enables,
//               registered read-first reads, power-up zeroing sweep and
//               out-of-range access flagging.
//               Define RAM_PARAM_PARITY_EN to add per-lane even parity
//               storage and a parity_err output.
// Revision    : 1.0  initial release
// ============================================================================
module ram_param
   import ram_param_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [DATA_W/8-1:0] be,
   input  logic                rd,
   input  logic                wr,
   output logic [DATA_W-1:0]   data_out,
   output logic                rd_valid,
   output logic                busy,
   output logic                oob_err
`ifdef RAM_PARAM_PARITY_EN
   ,
   output logic                parity_err
`endif
);

   localparam int c_NB    = DATA_W / 8;
   localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]    c_DEPTH_A = (ADDR_W + 1)'(DEPTH);

   state_t               state_q, state_d;
   logic [c_IDX_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [DATA_W-1:0]    data_out_q;
   logic                 rd_valid_q;
   logic                 oob_err_q;

   logic                 w_ready;
   logic                 w_in_range;
   logic [c_IDX_W-1:0]   w_idx;
   logic                 w_rd_acc;
   logic                 w_wr_acc;
   logic [DATA_W-1:0]    w_rdata;
   logic [DATA_W-1:0]    w_wdata;

   assign w_ready    = (state_q == READY);
   assign w_in_range = ({1'b0, address} < c_DEPTH_A);
   assign w_idx      = address[c_IDX_W-1:0];
   assign w_rd_acc   = w_ready & rd;
   assign w_wr_acc   = w_ready & wr & w_in_range;
   // Only meaningful when w_in_range; every consumer is gated by it
   assign w_rdata    = mem_q[w_idx];

   // Merge enabled byte lanes of the write data over the stored word
   always_comb begin
      w_wdata = w_rdata;
      for (int i = 0; i < c_NB; i++) begin
         if (be[i]) begin
            w_wdata[8*i +: 8] = data_in[8*i +: 8];
         end
      end
   end

   // Sweep sequencing: walk every address once, then settle in READY
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == CLEAR) begin
         if (ptr_q == c_LAST) begin
            state_d = READY;
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end
   end

   // State, sweep pointer and registered outputs; reset abandons any operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         ptr_q      <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         oob_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rd_valid_q <= w_rd_acc;
         // One pulse per access even if rd and wr are both asserted
         oob_err_q  <= w_ready & (rd | wr) & ~w_in_range;
         if (w_rd_acc) begin
            data_out_q <= w_in_range ? w_rdata : '0;
         end
      end
   end

   // Storage array: sweep zeroing has priority, port writes only in READY
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem_q[ptr_q] <= '0;
      end else if (w_wr_acc) begin
         mem_q[w_idx] <= w_wdata;
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign oob_err  = oob_err_q;
   assign busy     = (state_q == CLEAR);

`ifdef RAM_PARAM_PARITY_EN
   logic [c_NB-1:0] par_q [DEPTH];
   logic [c_NB-1:0] w_gen_par;
   logic [c_NB-1:0] w_chk_par;
   logic [c_NB-1:0] w_wpar;
   logic            parity_err_q;

   ram_param_parity #(.DATA_W(DATA_W)) u_par_gen (
      .data_i (data_in),
      .par_o  (w_gen_par)
   );

   ram_param_parity #(.DATA_W(DATA_W)) u_par_chk (
      .data_i (w_rdata),
      .par_o  (w_chk_par)
   );

   // Refresh parity only for lanes being written
   always_comb begin
      w_wpar = par_q[w_idx];
      for (int i = 0; i < c_NB; i++) begin
         if (be[i]) begin
            w_wpar[i] = w_gen_par[i];
         end
      end
   end

   // Parity storage follows the data array; all-zero words have zero parity
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         par_q[ptr_q] <= '0;
      end else if (w_wr_acc) begin
         par_q[w_idx] <= w_wpar;
      end
   end

   // Parity error flag pulses alongside rd_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= w_rd_acc & w_in_range & (|(w_chk_par ^ par_q[w_idx]));
      end
   end

   assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_param
// Description : Self-checking bench for ram_param against a word-array model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_param;

`ifdef RAM_PARAM_PARITY_EN
   localparam int DW = 16;
`else
   localparam int DW = 8;
`endif
   localparam int AW  = 8;
   localparam int DEP = 8;
   localparam int IW  = 3;
   localparam int NB  = DW / 8;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [NB-1:0] be;
   logic          rd;
   logic          wr;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          busy;
   logic          oob_err;
`ifdef RAM_PARAM_PARITY_EN
   logic          parity_err;
`endif

   ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .address  (addr),
      .data_in  (din),
      .be       (be),
      .rd       (rd),
      .wr       (wr),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .busy     (busy),
`ifdef RAM_PARAM_PARITY_EN
      .parity_err (parity_err),
`endif
      .oob_err  (oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain word array plus sweep countdown
   logic [DW-1:0] model [DEP];
   logic [NB-1:0] bad_lanes [DEP];
   int            sweep_left;
   logic [DW-1:0] exp_dout;
   int            n_cmp;
   int            n_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sweep_left = DEP;
      exp_dout   = '0;
      for (int i = 0; i < DEP; i++) begin
         model[i]     = '0;
         bad_lanes[i] = '0;
      end
   endtask

   // Assert reset asynchronously, check immediate outputs, then release
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_eq("rst_busy",     busy,     1);
      check_eq("rst_rd_valid", rd_valid, 0);
      check_eq("rst_oob_err",  oob_err,  0);
      check_eq("rst_data_out", data_out, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Advance one clock, predicting outputs from the current inputs
   task automatic tick();
      bit            exp_rv;
      bit            exp_oob;
      bit            exp_perr;
      bit            inr;
      logic [IW-1:0] a;
      exp_rv   = 0;
      exp_oob  = 0;
      exp_perr = 0;
      inr      = (int'(addr) < DEP);
      a        = addr[IW-1:0];
      if (sweep_left > 0) begin
         sweep_left--;
      end else begin
         if (rd) begin
            exp_rv   = 1;
            exp_dout = inr ? model[a] : '0;
            exp_perr = inr && (bad_lanes[a] != '0);
         end
         exp_oob = (rd || wr) && !inr;
         if (wr && inr) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) begin
                  model[a][8*i +: 8] = din[8*i +: 8];
                  bad_lanes[a][i]    = 1'b0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      check_eq("busy",     busy,     (sweep_left > 0));
      check_eq("rd_valid", rd_valid, exp_rv);
      check_eq("oob_err",  oob_err,  exp_oob);
      check_eq("data_out", data_out, exp_dout);
`ifdef RAM_PARAM_PARITY_EN
      check_eq("parity_err", parity_err, exp_perr);
`endif
   endtask

   task automatic set_in(input bit r, input bit w, input int a, input logic [DW-1:0] d, input logic [NB-1:0] b);
      rd   = r;
      wr   = w;
      addr = AW'(a);
      din  = d;
      be   = b;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_in(0, 0, 0, '0, '0);
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Sweep with ignored traffic, then read every word back-to-back
      for (int i = 0; i < DEP; i++) begin
         set_in(1, 1, i, '1, '1);
         tick();
      end
      for (int i = 0; i < DEP; i++) begin
         set_in(1, 0, i, '0, '0);
         tick();
      end

      // Write then read, then an all-lanes-disabled write
      set_in(0, 1, 1, DW'('h5A), '1); tick();
      set_in(1, 0, 1, '0, '0);        tick();
      set_in(0, 1, 1, '1, '0);        tick();
      set_in(1, 0, 1, '0, '0);        tick();

      // Read-first collision
      set_in(0, 1, 2, DW'('h11), '1); tick();
      set_in(1, 1, 2, DW'('h22), '1); tick();
      set_in(1, 0, 2, '0, '0);        tick();

      // Out-of-range write, read, combined access; mem[1] untouched
      set_in(0, 1, 9, '1, '1); tick();
      set_in(1, 0, 9, '0, '0); tick();
      set_in(1, 1, 9, '1, '1); tick();
      set_in(1, 0, 1, '0, '0); tick();
      set_in(0, 0, 0, '0, '0); tick();

      // Mid-sweep reset with writes attempted during the sweep
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, i, '1, '1);
         tick();
      end
      do_reset();
      for (int i = 0; i < DEP; i++) begin
         set_in(0, 1, DEP - 1 - i, '1, '1);
         tick();
      end
      for (int i = 0; i < DEP; i++) begin
         set_in(1, 0, i, '0, '0);
         tick();
      end

`ifdef RAM_PARAM_PARITY_EN
      // Corrupt one stored bit in lane 1 and read it back
      set_in(0, 1, 3, DW'('hA55A), '1); tick();
      set_in(0, 0, 0, '0, '0);
      dut.mem_q[3][8] = ~dut.mem_q[3][8];
      model[3][8]     = ~model[3][8];
      bad_lanes[3][1] = 1'b1;
      set_in(1, 0, 3, '0, '0); tick();
      set_in(0, 1, 3, DW'('h1234), 2'b10); tick();
      set_in(1, 0, 3, '0, '0); tick();
`endif

      // Randomised traffic, including one reset partway through
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin
            do_reset();
         end
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, DEP + 3)), DW'($urandom), NB'($urandom));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 SHALL: parameter DATA_W, default 8, word width in bits, multiple of 8.
REQ-002 SHALL: parameter ADDR_W, default 8, address width.
REQ-003 SHALL: parameter DEPTH, default 8, number of words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL: address  input  ADDR_W  word address for read and write.
REQ-007 SHALL: data_in  input  DATA_W  write data.
REQ-008 SHALL: be  input  DATA_W/8  byte-lane write enables; bit i covers data_in[8i+7:8i].
REQ-009 SHALL: rd  input  1  read request, sampled at posedge.
REQ-010 SHALL: wr  input  1  write request, sampled at posedge.
REQ-011 SHALL: data_out  output  DATA_W  registered read data.
REQ-012 SHALL: rd_valid  output  1  one-cycle pulse marking new data_out.
REQ-013 SHALL: busy  output  1  high during the initialisation sweep.
REQ-014 SHALL: oob_err  output  1  one-cycle pulse on an accepted access with address >= DEPTH.

Function
REQ-015 SHALL: FSM states CLEAR and READY; reset forces CLEAR with sweep pointer 0.
- CLEAR: one word per cycle written to all zeros, addresses 0..DEPTH-1 in order.
- CLEAR -> READY on the cycle after address DEPTH-1 is cleared, so busy is high for exactly DEPTH cycles after rst_n release.
REQ-016 SHALL: busy is 1 in CLEAR and 0 in READY; rd and wr are ignored while busy is 1.
- No rd_valid, no oob_err, no memory update from ports during CLEAR.
REQ-017 SHALL: in READY with wr=1 and address < DEPTH, the posedge updates only the byte lanes whose be bit is 1.
- be=0 with wr=1: no change to memory, no error.
REQ-018 SHALL: in READY with rd=1, data_out is loaded at that posedge with mem[address] and rd_valid=1 for that following cycle.
- Read latency: exactly 1 cycle.
- data_out holds its value when no read occurs.
REQ-019 SHALL: simultaneous rd and wr to the same address return the pre-write data (read-first); the write still takes effect.
REQ-020 SHALL: handle an access with address >= DEPTH as follows.
- Write: dropped.
- Read: data_out=0 and rd_valid=1.
- Either: oob_err=1 for one cycle, once per access even when rd and wr are both high.
REQ-021 SHALL: accept back-to-back reads on consecutive cycles, one result per cycle with no bubbles.

Reset
REQ-022 SHALL: on rst_n=0 the outputs take these values immediately, independent of clk.
- data_out=0, rd_valid=0, oob_err=0, busy=1.
REQ-023 SHALL: rst_n asserted mid-sweep or mid-access abandon that operation; after release the sweep restarts at address 0 and lasts a full DEPTH cycles.

Configuration
REQ-024 SHALL: macro RAM_PARAM_PARITY_EN, when defined, add parity storage and checking as follows.
- Store one even-parity bit per byte lane, updated with that lane.
- Add output parity_err (1 bit), pulsed with rd_valid when any lane of the read word mismatches.
- The CLEAR sweep writes consistent parity.
REQ-025 SHALL: with RAM_PARAM_PARITY_EN undefined, the block has no parity storage and no parity_err port; all other behaviour is identical.

Structure
REQ-026 SHALL: package ram_param_pkg hold the FSM state enum (CLEAR, READY) and the default values of DATA_W, ADDR_W and DEPTH.
REQ-027 SHALL: sub-module ram_param_parity compute per-byte even parity, instantiated for write-side generation and read-side check only under RAM_PARAM_PARITY_EN.

Verification
REQ-028 SHALL: cover these scenarios with defaults DATA_W=8, ADDR_W=8, DEPTH=8.
- Reset release: busy high for exactly 8 cycles; then rd at addresses 0..7 returns 0x00 each, each with rd_valid one cycle later.
- Write then read: wr addr 1 data 0x5A be=1, then rd addr 1 -> data_out=0x5A next cycle; then be=0 write of 0xFF leaves 0x5A.
- Read-first collision: mem[2]=0x11, then rd+wr addr 2 data 0x22 in the same cycle -> data_out=0x11; the next rd of addr 2 -> 0x22.
- Out of range: wr addr 9 then rd addr 9 -> oob_err pulses each time, data_out=0x00, rd_valid=1, and mem[1] is unchanged.
- Mid-sweep reset: rst_n low at sweep cycle 4 -> busy stays high; after release busy is high for 8 full cycles; wr during busy has no effect.
- With RAM_PARAM_PARITY_EN defined and DATA_W=16: force a bit flip in stored lane 1 -> the read raises parity_err together with rd_valid.
